// File: rtl/ecc_decrypt_core_pkg.sv
// Shared types, constants and field helpers for the ECC decryption core.
package ecc_decrypt_core_pkg;

    // Sequencer state encoding.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DBL   = 3'd1,
        S_ADD   = 3'd2,
        S_NEG   = 3'd3,
        S_FINAL = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    // Point at infinity (0:1:0); modules narrow these to the field width.
    localparam logic [31:0] INF_X = 32'd0;
    localparam logic [31:0] INF_Y = 32'd1;
    localparam logic [31:0] INF_Z = 32'd0;

    // Curve coefficient a of y^2 + xy = x^3 + a*x^2 + b.
    localparam logic [31:0] CURVE_A = 32'd1;

    // Low-order terms of the reduction polynomial for GF(2^n).
    function automatic logic [31:0] field_poly(input int unsigned n);
        case (n)
            5:       return 32'h0000_0005;
            8:       return 32'h0000_001B;
            default: return 32'h0000_0003;
        endcase
    endfunction

    // Shift-and-add multiply in GF(2^n); operands are zero-extended to 32 bits.
    function automatic logic [31:0] gf_mul(input logic [31:0] a, input logic [31:0] b,
                                           input int unsigned n, input logic [31:0] poly);
        logic [31:0] prod;
        logic [31:0] sh;
        logic [31:0] mask;
        logic [31:0] top;
        prod = '0;
        sh   = a;
        mask = (32'd1 << n) - 32'd1;
        top  = 32'd1 << (n - 32'd1);
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < n && b[5'(i)]) begin
                prod = prod ^ sh;
            end
            sh = ((sh << 1) & mask) ^ (((sh & top) != '0) ? poly : 32'd0);
        end
        return prod;
    endfunction

    // Y coordinate of -P in projective form: -(X:Y:Z) = (X : X xor Y : Z).
    function automatic logic [31:0] point_neg_y(input logic [31:0] x, input logic [31:0] y);
        return x ^ y;
    endfunction

endpackage

// File: rtl/pointAddition.sv
// Combinational projective point addition P1 + P2 for distinct, finite points.
// a_zero/b_zero flag equal Y / equal X so the caller can pick doubling or infinity.
module pointAddition
    import ecc_decrypt_core_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0] x1,
    input  logic [N-1:0] y1,
    input  logic [N-1:0] z1,
    input  logic [N-1:0] x2,
    input  logic [N-1:0] y2,
    input  logic [N-1:0] z2,
    output logic [N-1:0] x3,
    output logic [N-1:0] y3,
    output logic [N-1:0] z3,
    output logic         a_zero,
    output logic         b_zero
);

    localparam logic [N-1:0] CA = N'(CURVE_A);

    function automatic logic [N-1:0] fm(input logic [N-1:0] a, input logic [N-1:0] b);
        return N'(gf_mul(32'(a), 32'(b), N, field_poly(N)));
    endfunction

    logic [N-1:0] z12, x1z2, a_t, b_t, bb, bbb, e_t;

    // lambda = A/B with A = Y1Z2+Y2Z1, B = X1Z2+X2Z1; result over Z3 = B^3*Z1Z2.
    always_comb begin
        z12    = fm(z1, z2);
        x1z2   = fm(x1, z2);
        a_t    = fm(y1, z2) ^ fm(y2, z1);
        b_t    = x1z2 ^ fm(x2, z1);
        bb     = fm(b_t, b_t);
        bbb    = fm(bb, b_t);
        e_t    = fm(fm(a_t, a_t) ^ fm(a_t, b_t) ^ fm(CA, bb), z12) ^ bbb;
        x3     = fm(b_t, e_t);
        y3     = fm(a_t, fm(x1z2, bb) ^ e_t) ^ x3 ^ fm(fm(y1, z2), bbb);
        z3     = fm(bbb, z12);
        a_zero = (a_t == '0);
        b_zero = (b_t == '0);
    end

endmodule

// File: rtl/point_double.sv
// Combinational projective point doubling 2*P; a point with X=0 doubles to Z=0.
module point_double
    import ecc_decrypt_core_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0] x1,
    input  logic [N-1:0] y1,
    input  logic [N-1:0] z1,
    output logic [N-1:0] x3,
    output logic [N-1:0] y3,
    output logic [N-1:0] z3
);

    localparam logic [N-1:0] CA = N'(CURVE_A);

    function automatic logic [N-1:0] fm(input logic [N-1:0] a, input logic [N-1:0] b);
        return N'(gf_mul(32'(a), 32'(b), N, field_poly(N)));
    endfunction

    logic [N-1:0] xx, w, l, ww, f;

    // lambda = (X^2 + YZ)/(XZ); result over Z3 = (XZ)^3.
    always_comb begin
        xx = fm(x1, x1);
        w  = fm(x1, z1);
        l  = xx ^ fm(y1, z1);
        ww = fm(w, w);
        f  = fm(l, l) ^ fm(l, w) ^ fm(CA, ww);
        x3 = fm(f, w);
        y3 = fm(fm(xx, xx), w) ^ fm(l ^ w, f);
        z3 = fm(ww, w);
    end

endmodule

// File: rtl/ecc_decrypt_core.sv
// ECC decryption M = C2 - d*C1 via MSB-first double-and-add over GF(2^N).
module ecc_decrypt_core
    import ecc_decrypt_core_pkg::*;
#(
    parameter int unsigned N          = 3,
    parameter int unsigned KEY_W      = 4,
    parameter bit          CONST_TIME = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [KEY_W-1:0] key,
    input  logic [N-1:0]     x_C1,
    input  logic [N-1:0]     y_C1,
    input  logic [N-1:0]     z_C1,
    input  logic [N-1:0]     x_C2,
    input  logic [N-1:0]     y_C2,
    input  logic [N-1:0]     z_C2,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     x_Plaintext,
    output logic [N-1:0]     y_Plaintext,
    output logic [N-1:0]     z_Plaintext
);

    localparam int unsigned  IDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam logic [N-1:0] IX    = N'(INF_X);
    localparam logic [N-1:0] IY    = N'(INF_Y);
    localparam logic [N-1:0] IZ    = N'(INF_Z);

    state_e             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N-1:0]       c1x_q, c1y_q, c1z_q, c1x_d, c1y_d, c1z_d;
    logic [N-1:0]       c2x_q, c2y_q, c2z_q, c2x_d, c2y_d, c2z_d;
    logic [N-1:0]       accx_q, accy_q, accz_q, accx_d, accy_d, accz_d;
    logic [N-1:0]       ptx_q, pty_q, ptz_q, ptx_d, pty_d, ptz_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic [N-1:0]       bx, by, bz;
    logic [N-1:0]       sum_x, sum_y, sum_z, dbl_x, dbl_y, dbl_z;
    logic [N-1:0]       r_x, r_y, r_z;
    logic               sum_a_zero, sum_b_zero, key_bit, last_bit;

    // Shared arithmetic: adder sees acc and C1 (C2 in FINAL), doubler always sees acc.
    pointAddition #(.N(N)) u_add (
        .x1(accx_q), .y1(accy_q), .z1(accz_q),
        .x2(bx),     .y2(by),     .z2(bz),
        .x3(sum_x),  .y3(sum_y),  .z3(sum_z),
        .a_zero(sum_a_zero), .b_zero(sum_b_zero)
    );

    point_double #(.N(N)) u_dbl (
        .x1(accx_q), .y1(accy_q), .z1(accz_q),
        .x3(dbl_x),  .y3(dbl_y),  .z3(dbl_z)
    );

    // Second addend select and acc + b with infinity, equal-point and opposite-point cases.
    // When b equals acc the doubler output is exactly acc + b.
    always_comb begin
        bx = (state_q == S_FINAL) ? c2x_q : c1x_q;
        by = (state_q == S_FINAL) ? c2y_q : c1y_q;
        bz = (state_q == S_FINAL) ? c2z_q : c1z_q;
        if (accz_q == '0) begin
            r_x = bx;     r_y = by;     r_z = bz;
        end else if (bz == '0) begin
            r_x = accx_q; r_y = accy_q; r_z = accz_q;
        end else if (sum_b_zero && sum_a_zero) begin
            r_x = dbl_x;  r_y = dbl_y;  r_z = dbl_z;
        end else if (sum_b_zero) begin
            r_x = IX;     r_y = IY;     r_z = IZ;
        end else begin
            r_x = sum_x;  r_y = sum_y;  r_z = sum_z;
        end
        key_bit  = key_q[idx_q];
        last_bit = (idx_q == '0);
    end

    // Next-state and datapath updates for the scalar-multiply sequencer.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        c1x_d = c1x_q; c1y_d = c1y_q; c1z_d = c1z_q;
        c2x_d = c2x_q; c2y_d = c2y_q; c2z_d = c2z_q;
        accx_d = accx_q; accy_d = accy_q; accz_d = accz_q;
        ptx_d = ptx_q; pty_d = pty_q; ptz_d = ptz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d = key;
                    c1x_d = x_C1; c1y_d = y_C1; c1z_d = z_C1;
                    c2x_d = x_C2; c2y_d = y_C2; c2z_d = z_C2;
                    accx_d = IX; accy_d = IY; accz_d = IZ;
                    idx_d   = IDX_W'(KEY_W - 1);
                    state_d = S_DBL;
                end
            end
            S_DBL: begin
                if (accz_q == '0) begin
                    accx_d = IX; accy_d = IY; accz_d = IZ;
                end else begin
                    accx_d = dbl_x; accy_d = dbl_y; accz_d = dbl_z;
                end
                if (key_bit || CONST_TIME) begin
                    state_d = S_ADD;
                end else if (last_bit) begin
                    state_d = S_NEG;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            S_ADD: begin
                // With a zero key bit the adder still evaluates but its result is dropped.
                if (key_bit) begin
                    accx_d = r_x; accy_d = r_y; accz_d = r_z;
                end
                if (last_bit) begin
                    state_d = S_NEG;
                end else begin
                    idx_d   = idx_q - IDX_W'(1);
                    state_d = S_DBL;
                end
            end
            S_NEG: begin
                accy_d  = N'(point_neg_y(32'(accx_q), 32'(accy_q)));
                state_d = S_FINAL;
            end
            S_FINAL: begin
                ptx_d = r_x; pty_d = r_y; ptz_d = r_z;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = state_d inside {S_DBL, S_ADD, S_NEG, S_FINAL};
        done_d = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            c1x_q <= '0; c1y_q <= '0; c1z_q <= '0;
            c2x_q <= '0; c2y_q <= '0; c2z_q <= '0;
            accx_q <= '0; accy_q <= '0; accz_q <= '0;
            ptx_q <= '0; pty_q <= '0; ptz_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            c1x_q <= c1x_d; c1y_q <= c1y_d; c1z_q <= c1z_d;
            c2x_q <= c2x_d; c2y_q <= c2y_d; c2z_q <= c2z_d;
            accx_q <= accx_d; accy_q <= accy_d; accz_q <= accz_d;
            ptx_q <= ptx_d; pty_q <= pty_d; ptz_q <= ptz_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign x_Plaintext = ptx_q;
    assign y_Plaintext = pty_q;
    assign z_Plaintext = ptz_q;

endmodule
